// File: rtl/kernel_st_pkg.sv
// Shared types and helpers for the kernel_st ready-latency adapter.
// The framing-check states live here so any packet-aware block can reuse them.
package kernel_st_pkg;

    localparam logic [0:0] PKT_IDLE   = 1'b0;
    localparam logic [0:0] PKT_IN_PKT = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE   = PKT_IDLE,
        ST_IN_PKT = PKT_IN_PKT
    } pkt_state_e;

    // One stored beat is {data, sop, eop, empty}.
    function automatic int payload_w(input int data_w, input int empty_w);
        return data_w + empty_w + 2;
    endfunction

endpackage

// File: rtl/kernel_st_rl_fifo.sv
// Show-ahead FIFO with registered occupancy for the kernel_st adapter.
// The head entry is read asynchronously so a beat written at edge t is visible right after t.
module kernel_st_rl_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [FW-1:0]    fill_reg;
    logic [FW-1:0]    fill_next;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_comb begin
        fill_next = fill_reg;
        case ({push, pop})
            2'b10:   fill_next = fill_reg + 1'b1;
            2'b01:   fill_next = fill_reg - 1'b1;
            default: fill_next = fill_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            fill_reg <= fill_next;
        end
    end

    assign rdata      = mem[rd_ptr_reg];
    assign fill_level = fill_reg;

endmodule

// File: rtl/kernel_st_rl_adapter.sv
// Avalon-ST adapter from input ready latency IN_RL to output ready latency 0.
// Optional packet framing checker enabled by defining KERNEL_ST_PKT_CHECK_EN.
module kernel_st_rl_adapter
    import kernel_st_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int DEPTH   = 8,
    parameter int IN_RL   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    in_ready,
    input  logic                    in_valid,
    input  logic                    in_startofpacket,
    input  logic                    in_endofpacket,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [EMPTY_W-1:0]      in_empty,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic                    out_startofpacket,
    output logic                    out_endofpacket,
    output logic [DATA_W-1:0]       out_data,
    output logic [EMPTY_W-1:0]      out_empty,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic                    overflow,
    output logic                    pkt_error
);

    localparam int PW = payload_w(DATA_W, EMPTY_W);
    localparam int FW = $clog2(DEPTH) + 1;

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < IN_RL + 2) || (IN_RL > 3) || (IN_RL < 0))
    begin : g_bad_cfg
        $error("kernel_st_rl_adapter: DEPTH must be a power of 2 and >= IN_RL+2, IN_RL in 0..3");
    end

    localparam logic [FW-1:0] DEPTH_FILL = FW'(DEPTH);
    localparam logic [FW-1:0] RDY_LIMIT  = FW'(DEPTH - 1 - IN_RL);

    logic [FW-1:0] fill;
    logic [PW-1:0] wr_payload;
    logic [PW-1:0] rd_payload;
    logic          push;
    logic          pop;
    logic          overflow_reg;

    // Acceptance ignores in_ready: a sender honouring IN_RL may still land beats
    // up to IN_RL cycles after in_ready fell, and those must fit in the headroom.
    assign out_valid  = (fill != '0);
    assign pop        = out_valid & out_ready;
    assign push       = in_valid & ((fill < DEPTH_FILL) | pop);
    assign in_ready   = (fill <= RDY_LIMIT);
    assign fill_level = fill;
    assign wr_payload = {in_data, in_startofpacket, in_endofpacket, in_empty};

    kernel_st_rl_fifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .wdata      (wr_payload),
        .pop        (pop),
        .rdata      (rd_payload),
        .fill_level (fill)
    );

    always_comb begin
        out_data          = '0;
        out_startofpacket = 1'b0;
        out_endofpacket   = 1'b0;
        out_empty         = '0;
        if (out_valid) begin
            {out_data, out_startofpacket, out_endofpacket, out_empty} = rd_payload;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_reg <= 1'b0;
        end else if (in_valid && !push) begin
            overflow_reg <= 1'b1;
        end
    end

    assign overflow = overflow_reg;

`ifdef KERNEL_ST_PKT_CHECK_EN
    pkt_state_e state_reg;
    logic       pkt_error_reg;

    // Only accepted beats advance the checker; dropped beats are already flagged by overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            pkt_error_reg <= 1'b0;
        end else if (push) begin
            case (state_reg)
                ST_IDLE: begin
                    if (!in_startofpacket) begin
                        pkt_error_reg <= 1'b1;
                    end else if (!in_endofpacket) begin
                        state_reg <= ST_IN_PKT;
                    end
                end
                ST_IN_PKT: begin
                    if (in_startofpacket) begin
                        pkt_error_reg <= 1'b1;
                        state_reg     <= in_endofpacket ? ST_IDLE : ST_IN_PKT;
                    end else if (in_endofpacket) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign pkt_error = pkt_error_reg;
`else
    assign pkt_error = 1'b0;
`endif

endmodule

// File: tb/tb_kernel_st_rl_adapter.sv
// Directed bench: instance a (DEPTH=8, IN_RL=2) and instance b (DEPTH=4, IN_RL=0).
module tb_kernel_st_rl_adapter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

`ifdef KERNEL_ST_PKT_CHECK_EN
    localparam logic PKT_EXP = 1'b1;
`else
    localparam logic PKT_EXP = 1'b0;
`endif

    // Instance a
    logic        a_reset, a_in_ready, a_in_valid, a_sop, a_eop, a_out_ready;
    logic        a_out_valid, a_out_sop, a_out_eop, a_overflow, a_pkt_error;
    logic [31:0] a_data, a_out_data;
    logic [1:0]  a_empty, a_out_empty;
    logic [3:0]  a_fill;

    // Instance b
    logic        b_reset, b_in_ready, b_in_valid, b_sop, b_eop, b_out_ready;
    logic        b_out_valid, b_out_sop, b_out_eop, b_overflow, b_pkt_error;
    logic [31:0] b_data, b_out_data;
    logic [1:0]  b_empty, b_out_empty;
    logic [2:0]  b_fill;

    kernel_st_rl_adapter #(.DATA_W(32), .EMPTY_W(2), .DEPTH(8), .IN_RL(2)) u_a (
        .clk(clk), .reset(a_reset), .in_ready(a_in_ready), .in_valid(a_in_valid),
        .in_startofpacket(a_sop), .in_endofpacket(a_eop), .in_data(a_data), .in_empty(a_empty),
        .out_ready(a_out_ready), .out_valid(a_out_valid), .out_startofpacket(a_out_sop),
        .out_endofpacket(a_out_eop), .out_data(a_out_data), .out_empty(a_out_empty),
        .fill_level(a_fill), .overflow(a_overflow), .pkt_error(a_pkt_error)
    );

    kernel_st_rl_adapter #(.DATA_W(32), .EMPTY_W(2), .DEPTH(4), .IN_RL(0)) u_b (
        .clk(clk), .reset(b_reset), .in_ready(b_in_ready), .in_valid(b_in_valid),
        .in_startofpacket(b_sop), .in_endofpacket(b_eop), .in_data(b_data), .in_empty(b_empty),
        .out_ready(b_out_ready), .out_valid(b_out_valid), .out_startofpacket(b_out_sop),
        .out_endofpacket(b_out_eop), .out_data(b_out_data), .out_empty(b_out_empty),
        .fill_level(b_fill), .overflow(b_overflow), .pkt_error(b_pkt_error)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_b [4];
        int   sent, rcvd, cyc;
        logic toggle;

        a_reset = 1'b1; a_in_valid = 1'b0; a_sop = 1'b0; a_eop = 1'b0;
        a_data = '0; a_empty = '0; a_out_ready = 1'b0;
        b_reset = 1'b1; b_in_valid = 1'b0; b_sop = 1'b1; b_eop = 1'b1;
        b_data = '0; b_empty = '0; b_out_ready = 1'b0;
        repeat (2) tick();
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Reset state
        check_eq("rst_fill",     a_fill, 0);
        check_eq("rst_valid",    a_out_valid, 0);
        check_eq("rst_in_ready", a_in_ready, 1);
        check_eq("rst_data",     a_out_data, 0);
        check_eq("rst_sop",      a_out_sop, 0);
        check_eq("rst_overflow", a_overflow, 0);
        check_eq("rst_pkt_err",  a_pkt_error, 0);
        check_eq("rst_b_ready",  b_in_ready, 1);

        // a: fill with out_ready=0, in_ready falls at fill_level 6
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1; a_sop = 1'b1; a_eop = 1'b1;
            a_data = 32'h100 + i; a_empty = 2'(i);
            tick();
            check_eq($sformatf("a_fill_%0d", i), a_fill, i + 1);
            check_eq($sformatf("a_ready_%0d", i), a_in_ready, (i + 1 <= 5) ? 1 : 0);
        end
        check_eq("a_ovf_full8", a_overflow, 0);

        // 9th beat is dropped
        a_data = 32'h1FF;
        tick();
        a_in_valid = 1'b0;
        check_eq("a_fill_9th",  a_fill, 8);
        check_eq("a_ovf_9th",   a_overflow, 1);
        check_eq("a_head_sop",  a_out_sop, 1);
        check_eq("a_head_eop",  a_out_eop, 1);
        check_eq("a_head_empty", a_out_empty, 0);

        // Drain: exactly the first 8 beats, in order
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("a_drain_%0d", i), a_out_data, 32'h100 + i);
            tick();
        end
        a_out_ready = 1'b0;
        check_eq("a_empty_valid", a_out_valid, 0);
        check_eq("a_empty_data",  a_out_data, 0);
        check_eq("a_empty_sop",   a_out_sop, 0);
        check_eq("a_ovf_sticky",  a_overflow, 1);

        // Reset mid-packet with fill_level=5
        a_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_sop = (i == 0); a_eop = 1'b0; a_data = 32'h200 + i;
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("a_fill5", a_fill, 5);
        a_reset = 1'b1;
        tick();
        a_reset = 1'b0;
        check_eq("a_mid_rst_fill",  a_fill, 0);
        check_eq("a_mid_rst_valid", a_out_valid, 0);
        check_eq("a_mid_rst_ready", a_in_ready, 1);
        check_eq("a_mid_rst_data",  a_out_data, 0);
        check_eq("a_mid_rst_ovf",   a_overflow, 0);

        // Framing: sop, sop, eop (first sop also shows the checker restarted in IDLE)
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_sop = 1'b1; a_eop = 1'b0; a_data = 32'h300;
        tick();
        check_eq("pkt_beat1", a_pkt_error, 0);
        a_data = 32'h301;
        tick();
        check_eq("pkt_beat2", a_pkt_error, PKT_EXP);
        a_sop = 1'b0; a_eop = 1'b1; a_data = 32'h302;
        tick();
        a_in_valid = 1'b0;
        check_eq("pkt_beat3", a_pkt_error, PKT_EXP);
        check_eq("pkt_ovf",   a_overflow, 0);

        // b: 0xA0..0xA9 with out_ready toggling 1,0
        sent = 0; rcvd = 0; cyc = 0; toggle = 1'b1;
        while (rcvd < 10 && cyc < 200) begin
            b_out_ready = toggle;
            toggle = ~toggle;
            b_in_valid = (sent < 10) && b_in_ready;
            b_data = 32'hA0 + sent;
            if (b_out_valid && b_out_ready) begin
                check_eq($sformatf("b_order_%0d", rcvd), b_out_data, 32'hA0 + rcvd);
                rcvd++;
            end
            if (b_in_valid) sent++;
            tick();
            cyc++;
        end
        b_in_valid = 1'b0;
        b_out_ready = 1'b0;
        check_eq("b_count", rcvd, 10);
        check_eq("b_ovf",   b_overflow, 0);
        check_eq("b_fill0", b_fill, 0);

        // b: full at 4, then push and pop together
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1; b_data = 32'hB0 + i; b_empty = 2'(i);
            tick();
        end
        check_eq("b_fill4",  b_fill, 4);
        check_eq("b_ready4", b_in_ready, 0);
        check_eq("b_head_empty", b_out_empty, 0);
        b_data = 32'hEE; b_empty = 2'd3; b_out_ready = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check_eq("b_pp_fill", b_fill, 4);
        check_eq("b_pp_ovf",  b_overflow, 0);
        check_eq("b_pp_empty", b_out_empty, 1);
        exp_b[0] = 32'hB1; exp_b[1] = 32'hB2; exp_b[2] = 32'hB3; exp_b[3] = 32'hEE;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("b_drain_%0d", i), b_out_data, exp_b[i]);
            tick();
        end
        b_out_ready = 1'b0;
        check_eq("b_final_valid", b_out_valid, 0);
        check_eq("b_final_data",  b_out_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kernel_st_rl_adapter.md
KERNEL_ST_RL_ADAPTER -- requirements
Module: kernel_st_rl_adapter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of in_data and out_data.
REQ-002 SHALL have parameter EMPTY_W, default 2, width of in_empty and out_empty.
REQ-003 SHALL have parameter DEPTH, default 8, FIFO entries; power of 2; at least IN_RL+2.
REQ-004 SHALL have parameter IN_RL, default 0, input ready latency in cycles (range 0..3).
REQ-005 SHALL have one clock and one reset: the reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port in_ready, output, 1, sink ready, valid for beats IN_RL cycles later.
REQ-009 SHALL have ports in_valid/in_startofpacket/in_endofpacket, input, 1 each, Avalon-ST beat qualifiers.
REQ-010 SHALL have ports in_data (input, DATA_W) and in_empty (input, EMPTY_W), beat payload.
REQ-011 SHALL have port out_ready, input, 1, downstream ready, ready latency 0.
REQ-012 SHALL have ports out_valid/out_startofpacket/out_endofpacket, output, 1 each.
REQ-013 SHALL have ports out_data (output, DATA_W) and out_empty (output, EMPTY_W).
REQ-014 SHALL have port fill_level, output, $clog2(DEPTH)+1, registered occupancy.
REQ-015 SHALL have port overflow, output, 1, sticky: beat dropped.
REQ-016 SHALL have port pkt_error, output, 1, sticky: packet framing violation.

Function
REQ-017 SHALL drive in_ready = (fill_level <= DEPTH-1-IN_RL), combinationally from registered fill_level.
REQ-018 SHALL accept an input beat when in_valid=1 and either fill_level<DEPTH or a pop occurs in the same cycle; in_ready is not consulted at accept time.
REQ-019 SHALL drop a beat with in_valid=1 that cannot be accepted, and set overflow on the next edge.
REQ-020 SHALL store {data, sop, eop, empty} per beat and present it show-ahead; out_valid = (fill_level != 0).
REQ-021 SHALL pop when out_valid & out_ready; first-word latency is 1 cycle (written at edge t, visible after edge t).
REQ-022 SHALL, on simultaneous push and pop, keep fill_level unchanged and preserve order.
REQ-023 SHALL wrap read and write pointers modulo DEPTH with no lost or duplicated beats.
REQ-024 SHALL force out_data, out_startofpacket, out_endofpacket and out_empty to 0 while out_valid=0.
REQ-025 SHALL check framing on accepted input beats only, using FSM states IDLE and IN_PKT.
REQ-026 SHALL in IDLE: on sop&!eop go to IN_PKT; on sop&eop stay IDLE; on !sop set pkt_error and stay IDLE.
REQ-027 SHALL in IN_PKT: on eop (without sop) go to IDLE; on sop set pkt_error, go to IDLE if eop, else stay IN_PKT.
REQ-028 SHALL keep overflow and pkt_error set until reset.

Reset
REQ-029 SHALL on reset clear pointers, fill_level, overflow and pkt_error, set FSM to IDLE, and drive out_valid=0.
REQ-030 SHALL after reset drive in_ready=1 and all out_* payload outputs to 0.
REQ-031 SHALL discard all buffered beats when reset is asserted mid-packet or mid-burst.

Configuration
REQ-032 SHALL compile the framing checker (REQ-025..027) only when KERNEL_ST_PKT_CHECK_EN is defined.
REQ-033 SHALL, without KERNEL_ST_PKT_CHECK_EN, tie pkt_error to 0 and instantiate no FSM; all other behaviour unchanged.

Structure
REQ-034 SHALL place the framing FSM state enum and the payload-width helper (DATA_W+EMPTY_W+2) in shared package kernel_st_pkg.
REQ-035 SHALL implement storage as sub-module kernel_st_rl_fifo (show-ahead, fill level output).
REQ-036 SHALL fail elaboration if DEPTH is not a power of 2, DEPTH < IN_RL+2, or IN_RL > 3.

Verification
REQ-037 SHALL verify DEPTH=8, IN_RL=2, out_ready=0, continuous in_valid: in_ready falls once fill_level=6; 8 beats stored; overflow=0.
REQ-038 SHALL verify same config, in_valid held for 9 beats: 9th beat dropped, overflow=1, fill_level=8.
REQ-039 SHALL verify DEPTH=4, IN_RL=0, push data 0xA0..0xA9 with out_ready toggling 1,0: out_data sequence 0xA0..0xA9 in order, no loss.
REQ-040 SHALL verify with fill_level=4, push and pop together: fill_level stays 4, beat accepted, overflow=0.
REQ-041 SHALL verify with KERNEL_ST_PKT_CHECK_EN defined, sop, sop, eop: pkt_error=1 after 2nd beat; the same sequence with the macro undefined gives pkt_error=0.
REQ-042 SHALL verify reset asserted with fill_level=5 mid-packet: next cycle fill_level=0, out_valid=0, in_ready=1, FSM in IDLE.
